sync_fifo: RTL and testbench

Parametrised single-clock FIFO that generalises the team's earlier dual-port FIFO memory into a complete buffer. It has its own pointer and occupancy logic, full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable standard or first-word-fall-through (FWFT) read mode. It sits between single-clock producers and consumers in the system, for example register-file command queues and ALU result buffering.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/sync_fifo_ram.sv | 26 ++
 rtl/sync_fifo.sv | 130 +++++++++++++
 tb/tb_sync_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode selectors and pointer sizing.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Address bits plus one wrap bit, so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
// The array has no reset; only the control logic around it does.
module sync_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags, sticky error flags and
// a selectable standard (registered) or first-word-fall-through read stage.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FIFO_STD
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_rd_en,
    input  logic                   i_clr_err,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_rvalid,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_almost_full,
    output logic                   o_almost_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    logic [PW-1:0]    r_wr_ptr, r_rd_ptr, r_count;
    logic [PW-1:0]    w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
    logic             r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic             w_wr_acc, w_rd_acc;
    logic [WIDTH-1:0] w_head;

    // Accepts look only at registered flags, so a pop never frees room for a
    // same-cycle push when full, nor a push feeds a same-cycle pop when empty.
    assign w_wr_acc     = i_wr_en & ~r_full;
    assign w_rd_acc     = i_rd_en & ~r_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
    assign w_count_nxt  = r_count + PW'(w_wr_acc) - PW'(w_rd_acc);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                        (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_af     <= (w_count_nxt >= AF_L);
            r_ae     <= (w_count_nxt <= AE_L);
            r_ovf    <= (i_wr_en & r_full)  | (r_ovf & ~i_clr_err);
            r_unf    <= (i_rd_en & r_empty) | (r_unf & ~i_clr_err);
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wdata   (i_wdata),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rdata   (w_head)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Remembers the last popped word so rdata is stable while empty.
            logic [WIDTH-1:0] r_last;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_last <= '0;
                end else if (w_rd_acc) begin
                    r_last <= w_head;
                end
            end

            assign o_rdata  = r_empty ? r_last : w_head;
            assign o_rvalid = ~r_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;
            logic             r_rvalid;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rdata <= w_head;
                    end
                end
            end

            assign o_rdata  = r_rdata;
            assign o_rvalid = r_rvalid;
        end
    endgenerate

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_af;
    assign o_almost_empty = r_ae;
    assign o_count        = r_count;
    assign o_overflow     = r_ovf;
    assign o_underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: one standard-mode and one FWFT instance, default 8x16 geometry.
module tb_sync_fifo;

    logic       clk;
    int         errors;
    int         checks;

    logic       s_rst, s_wr_en, s_rd_en, s_clr_err;
    logic [7:0] s_wdata, s_rdata;
    logic       s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0] s_count;

    logic       f_rst, f_wr_en, f_rd_en, f_clr_err;
    logic [7:0] f_wdata, f_rdata;
    logic       f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_count;

    sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .i_clk(clk), .i_rst(s_rst), .i_wr_en(s_wr_en), .i_wdata(s_wdata),
        .i_rd_en(s_rd_en), .i_clr_err(s_clr_err), .o_rdata(s_rdata), .o_rvalid(s_rvalid),
        .o_full(s_full), .o_empty(s_empty), .o_almost_full(s_af), .o_almost_empty(s_ae),
        .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_unf)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .i_clk(clk), .i_rst(f_rst), .i_wr_en(f_wr_en), .i_wdata(f_wdata),
        .i_rd_en(f_rd_en), .i_clr_err(f_clr_err), .o_rdata(f_rdata), .o_rvalid(f_rvalid),
        .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae),
        .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        s_rst = 1'b1; f_rst = 1'b1;
        tick; tick;
        s_rst = 1'b0; f_rst = 1'b0;
        checks++;
        if ({s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_rvalid} !== 7'b0101000) begin
            errors++;
            $display("FAIL reset_std_flags: got %b expected 0101000",
                     {s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_rvalid});
        end
        checks++;
        if (s_count !== 5'd0 || s_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_std_count_rdata: got count=%0d rdata=%h expected 0/00", s_count, s_rdata);
        end
        checks++;
        if ({f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_rvalid} !== 7'b0101000 ||
            f_count !== 5'd0 || f_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_fwft: got flags=%b count=%0d rdata=%h expected 0101000/0/00",
                     {f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_rvalid}, f_count, f_rdata);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            s_wr_en = 1'b1; s_wdata = 8'(i);
            tick;
            checks++;
            if (s_count !== 5'(i) || s_af !== (i >= 14) || s_full !== (i == 16) ||
                s_ae !== (i <= 2) || s_empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: got count=%0d af=%b full=%b ae=%b empty=%b", i,
                         s_count, s_af, s_full, s_ae, s_empty);
            end
        end
        s_wdata = 8'h77;
        tick;
        s_wr_en = 1'b0;
        checks++;
        if (s_count !== 5'd16 || s_ovf !== 1'b1 || s_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_write: got count=%0d ovf=%b full=%b expected 16/1/1",
                     s_count, s_ovf, s_full);
        end
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 16; i++) begin
            s_rd_en = 1'b1;
            tick;
            checks++;
            if (s_rdata !== 8'(i) || s_rvalid !== 1'b1 || s_count !== 5'(16 - i)) begin
                errors++;
                $display("FAIL drain_%0d: got rdata=%h rvalid=%b count=%0d expected %h/1/%0d",
                         i, s_rdata, s_rvalid, s_count, 8'(i), 16 - i);
            end
        end
        s_rd_en = 1'b0;
        tick;
        checks++;
        if (s_rvalid !== 1'b0 || s_empty !== 1'b1 || s_rdata !== 8'h10 || s_full !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got rvalid=%b empty=%b rdata=%h full=%b expected 0/1/10/0",
                     s_rvalid, s_empty, s_rdata, s_full);
        end
        s_rd_en = 1'b1;
        tick;
        s_rd_en = 1'b0;
        checks++;
        if (s_unf !== 1'b1 || s_rvalid !== 1'b0 || s_count !== 5'd0) begin
            errors++;
            $display("FAIL underflow_read: got unf=%b rvalid=%b count=%0d expected 1/0/0",
                     s_unf, s_rvalid, s_count);
        end
        s_clr_err = 1'b1;
        tick;
        s_clr_err = 1'b0;
        checks++;
        if (s_unf !== 1'b0 || s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: got unf=%b ovf=%b expected 0/0", s_unf, s_ovf);
        end
    endtask

    task automatic test_back_to_back;
        s_wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_wdata = 8'(8'h20 + i);
            tick;
        end
        s_rd_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_wdata = 8'(8'h25 + k);
            tick;
            checks++;
            if (s_rdata !== 8'(8'h20 + k) || s_rvalid !== 1'b1 || s_count !== 5'd5 ||
                {s_full, s_empty, s_af, s_ae, s_ovf, s_unf} !== 6'b000000) begin
                errors++;
                $display("FAIL b2b_%0d: got rdata=%h rvalid=%b count=%0d flags=%b expected %h/1/5/000000",
                         k, s_rdata, s_rvalid, s_count,
                         {s_full, s_empty, s_af, s_ae, s_ovf, s_unf}, 8'(8'h20 + k));
            end
        end
        s_wr_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick;
            checks++;
            if (s_rdata !== 8'(8'h48 + j)) begin
                errors++;
                $display("FAIL b2b_tail_%0d: got %h expected %h", j, s_rdata, 8'(8'h48 + j));
            end
        end
        s_rd_en = 1'b0;
        tick;
        checks++;
        if (s_empty !== 1'b1 || s_count !== 5'd0) begin
            errors++;
            $display("FAIL b2b_empty: got empty=%b count=%0d expected 1/0", s_empty, s_count);
        end
    endtask

    task automatic test_simultaneous_edges;
        s_rd_en = 1'b1; s_clr_err = 1'b1;
        tick;
        s_rd_en = 1'b0;
        checks++;
        if (s_unf !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_clear: got unf=%b expected 1", s_unf);
        end
        tick;
        s_clr_err = 1'b0;
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wdata = 8'h5A;
        tick;
        s_rd_en = 1'b0;
        checks++;
        if (s_count !== 5'd1 || s_unf !== 1'b1 || s_rvalid !== 1'b0 || s_empty !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_empty: got count=%0d unf=%b rvalid=%b empty=%b expected 1/1/0/0",
                     s_count, s_unf, s_rvalid, s_empty);
        end
        for (int i = 0; i < 15; i++) begin
            s_wdata = 8'(8'h60 + i);
            tick;
        end
        checks++;
        if (s_full !== 1'b1 || s_count !== 5'd16) begin
            errors++;
            $display("FAIL refill_full: got full=%b count=%0d expected 1/16", s_full, s_count);
        end
        s_rd_en = 1'b1; s_wdata = 8'hEE;
        tick;
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        checks++;
        if (s_count !== 5'd15 || s_ovf !== 1'b1 || s_full !== 1'b0 ||
            s_rvalid !== 1'b1 || s_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL wr_rd_full: got count=%0d ovf=%b full=%b rvalid=%b rdata=%h expected 15/1/0/1/5A",
                     s_count, s_ovf, s_full, s_rvalid, s_rdata);
        end
    endtask

    task automatic test_reset_midstream;
        s_rd_en = 1'b1;
        for (int i = 0; i < 6; i++) tick;
        checks++;
        if (s_count !== 5'd9) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d expected 9", s_count);
        end
        s_rst = 1'b1; s_wr_en = 1'b1; s_wdata = 8'hFF;
        tick;
        s_rst = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        checks++;
        if (s_count !== 5'd0 || {s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_rvalid} !== 7'b0101000 ||
            s_rdata !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got count=%0d flags=%b rdata=%h expected 0/0101000/00",
                     s_count, {s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_rvalid}, s_rdata);
        end
        s_wr_en = 1'b1; s_wdata = 8'h3C;
        tick;
        s_wr_en = 1'b0; s_rd_en = 1'b1;
        checks++;
        if (s_count !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_write: got count=%0d expected 1", s_count);
        end
        tick;
        s_rd_en = 1'b0;
        checks++;
        if (s_rdata !== 8'h3C || s_rvalid !== 1'b1 || s_empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_read: got rdata=%h rvalid=%b empty=%b expected 3C/1/1",
                     s_rdata, s_rvalid, s_empty);
        end
    endtask

    task automatic test_fwft;
        f_wr_en = 1'b1; f_wdata = 8'hA5;
        tick;
        f_wr_en = 1'b0;
        checks++;
        if (f_rdata !== 8'hA5 || f_rvalid !== 1'b1 || f_empty !== 1'b0) begin
            errors++;
            $display("FAIL fwft_first: got rdata=%h rvalid=%b empty=%b expected A5/1/0",
                     f_rdata, f_rvalid, f_empty);
        end
        f_wr_en = 1'b1; f_wdata = 8'hB6;
        tick;
        f_wr_en = 1'b0;
        checks++;
        if (f_rdata !== 8'hA5 || f_count !== 5'd2) begin
            errors++;
            $display("FAIL fwft_hold_head: got rdata=%h count=%0d expected A5/2", f_rdata, f_count);
        end
        f_rd_en = 1'b1;
        tick;
        checks++;
        if (f_rdata !== 8'hB6 || f_rvalid !== 1'b1 || f_count !== 5'd1) begin
            errors++;
            $display("FAIL fwft_pop1: got rdata=%h rvalid=%b count=%0d expected B6/1/1",
                     f_rdata, f_rvalid, f_count);
        end
        tick;
        f_rd_en = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || f_rvalid !== 1'b0 || f_rdata !== 8'hB6 || f_unf !== 1'b0) begin
            errors++;
            $display("FAIL fwft_pop2: got empty=%b rvalid=%b rdata=%h unf=%b expected 1/0/B6/0",
                     f_empty, f_rvalid, f_rdata, f_unf);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        s_rst = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr_err = 1'b0; s_wdata = 8'h00;
        f_rst = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wdata = 8'h00;
        #2;
        test_reset;
        test_fill;
        test_drain;
        test_back_to_back;
        test_simultaneous_edges;
        test_reset_midstream;
        test_fwft;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
